// File: rtl/random_pkg.sv
// Shared definitions for the Galois-LFSR word generator: FSM state type,
// default tap masks for common widths, the reset seed and the step function
// used both by the hardware and by the bench reference model.
package random_pkg;

   // Widest state register the shared step function can model
   localparam int LFSR_MAX_WIDTH = 64;

   // Maximal-length Galois tap masks (bit N-1 set) for common widths
   localparam logic [3:0]  POLY_4  = 4'hC;
   localparam logic [7:0]  POLY_8  = 8'hB8;
   localparam logic [15:0] POLY_16 = 16'hB400;
   localparam logic [31:0] POLY_32 = 32'h80200003;

   // Reset seed, also substituted whenever a zero seed is loaded
   localparam logic [31:0] DEFAULT_SEED = 32'h974CA351;

   // FILL gathers W output bits, HOLD presents the finished word
   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } gen_state_t;

   // One Galois step: shift right, fold the tap mask in when the
   // outgoing bit is set. Narrower registers pass zero-extended values.
   function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
      input logic [LFSR_MAX_WIDTH-1:0] cur,
      input logic [LFSR_MAX_WIDTH-1:0] poly
   );
      return (cur >> 1) ^ (cur[0] ? poly : '0);
   endfunction

endpackage

// File: rtl/random_lfsr_core.sv
// LFSR state register plus its combinational Galois step. A load request
// wins over a step; a zero load value is replaced by INIT_SEED so the
// register can never enter the all-zero lock-up state.
module random_lfsr_core
   import random_pkg::*;
#(
   parameter int                    LFSR_WIDTH = 32,
   parameter logic [LFSR_WIDTH-1:0] POLY       = LFSR_WIDTH'(POLY_32),
   parameter logic [LFSR_WIDTH-1:0] INIT_SEED  = LFSR_WIDTH'(DEFAULT_SEED)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [LFSR_WIDTH-1:0] seed,
   input  logic                  step,
   output logic [LFSR_WIDTH-1:0] state,
   output logic                  fb_bit
);

   logic [LFSR_WIDTH-1:0] step_value;
   logic [LFSR_WIDTH-1:0] load_value;

   // Next state for a step, and the seed with zero replaced by INIT_SEED
   always_comb begin
      step_value = LFSR_WIDTH'(lfsr_step(LFSR_MAX_WIDTH'(state), LFSR_MAX_WIDTH'(POLY)));
      load_value = (seed == '0) ? INIT_SEED : seed;
   end

   // State register: reseed has priority over stepping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT_SEED;
      end else if (load) begin
         state <= load_value;
      end else if (step) begin
         state <= step_value;
      end
   end

   assign fb_bit = state[0];

endmodule

// File: rtl/random_lfsr_gen.sv
// Pseudo-random word generator: one LFSR step per enabled FILL cycle shifts
// one bit into the word; after OUT_WIDTH bits the word is presented with
// valid/ready and the LFSR stalls until it is taken. seed_load reseeds and
// drops any partial or pending word.
// Optional transfer counter word_cnt: define RANDOM_LFSR_STAT_EN.
module random_lfsr_gen
   import random_pkg::*;
#(
   parameter int                    LFSR_WIDTH = 32,
   parameter logic [LFSR_WIDTH-1:0] POLY       = LFSR_WIDTH'(POLY_32),
   parameter int                    OUT_WIDTH  = 16,
   parameter logic [LFSR_WIDTH-1:0] INIT_SEED  = LFSR_WIDTH'(DEFAULT_SEED)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  seed_load,
   input  logic [LFSR_WIDTH-1:0] seed,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LFSR_WIDTH-1:0] state
`ifdef RANDOM_LFSR_STAT_EN
   ,
   output logic [31:0]           word_cnt
`endif
);

   localparam int CNT_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_WIDTH - 1);

   gen_state_t            fsm_state;
   gen_state_t            fsm_next;
   logic [CNT_W-1:0]      bit_cnt;
   logic [OUT_WIDTH-1:0]  sh;
   logic [OUT_WIDTH-1:0]  sh_next;
   logic                  fb_bit;
   logic                  do_step;
   logic                  word_done;
   logic                  xfer;

   random_lfsr_core #(
      .LFSR_WIDTH (LFSR_WIDTH),
      .POLY       (POLY),
      .INIT_SEED  (INIT_SEED)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (seed_load),
      .seed   (seed),
      .step   (do_step),
      .state  (state),
      .fb_bit (fb_bit)
   );

   // Shift register contents after taking the current output bit at the LSB
   always_comb begin
      sh_next = (sh << 1) | OUT_WIDTH'(fb_bit);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_state <= FILL;
      end else begin
         fsm_state <= fsm_next;
      end
   end

   // Next state plus step/complete/transfer strobes; reseed overrides all
   always_comb begin
      fsm_next  = fsm_state;
      do_step   = 1'b0;
      word_done = 1'b0;
      xfer      = 1'b0;
      if (seed_load) begin
         fsm_next = FILL;
      end else begin
         case (fsm_state)
            FILL: begin
               if (en) begin
                  do_step = 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     word_done = 1'b1;
                     fsm_next  = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  xfer     = 1'b1;
                  fsm_next = FILL;
               end
            end
            default: fsm_next = FILL;
         endcase
      end
   end

   // Bit counter, shift register and output word with its valid flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         sh        <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (seed_load) begin
         bit_cnt   <= '0;
         sh        <= '0;
         out_valid <= 1'b0;
      end else if (do_step) begin
         sh <= sh_next;
         if (word_done) begin
            bit_cnt   <= '0;
            out_data  <= sh_next;
            out_valid <= 1'b1;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end else if (xfer) begin
         out_valid <= 1'b0;
      end
   end

`ifdef RANDOM_LFSR_STAT_EN
   // Count accepted words; reseed clears it and swallows a coincident transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
      end else if (seed_load) begin
         word_cnt <= '0;
      end else if (xfer) begin
         word_cnt <= word_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_random_lfsr_gen.sv
// Self-checking bench for random_lfsr_gen: a default-parameter instance for
// timing, backpressure, reseed and pause behaviour, and a 4-bit instance
// for a full-period walk. Expected words come from a queue filled by a
// reference model when stimulus is applied.
module tb_random_lfsr_gen;
   import random_pkg::*;

   localparam int          W     = 16;
   localparam logic [31:0] SEED0 = 32'h974CA351;
   localparam logic [31:0] POLY0 = 32'h80200003;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        seed_load;
   logic [31:0] seed;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic [31:0] state;

   logic        en4;
   logic        seed_load4;
   logic [3:0]  seed4;
   logic        out_ready4;
   logic [0:0]  out_data4;
   logic        out_valid4;
   logic [3:0]  state4;

`ifdef RANDOM_LFSR_STAT_EN
   logic [31:0] word_cnt;
   logic [31:0] word_cnt4;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mstate;
   logic [15:0] exp_q[$];
   int          exp_cnt;

   always #5 clk = ~clk;

   random_lfsr_gen dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .seed_load (seed_load),
      .seed      (seed),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state     (state)
`ifdef RANDOM_LFSR_STAT_EN
      ,
      .word_cnt  (word_cnt)
`endif
   );

   random_lfsr_gen #(
      .LFSR_WIDTH (4),
      .POLY       (4'hC),
      .OUT_WIDTH  (1),
      .INIT_SEED  (4'h1)
   ) dut4 (
      .clk       (clk),
      .rst       (rst),
      .en        (en4),
      .seed_load (seed_load4),
      .seed      (seed4),
      .out_data  (out_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .state     (state4)
`ifdef RANDOM_LFSR_STAT_EN
      ,
      .word_cnt  (word_cnt4)
`endif
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic sl, input logic [31:0] sd, input logic rdy);
      en        = e;
      seed_load = sl;
      seed      = sd;
      out_ready = rdy;
   endtask

   task automatic pushModelWord();
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         w      = {w[14:0], mstate[0]};
         mstate = 32'(lfsr_step(64'(mstate), 64'(POLY0)));
      end
      exp_q.push_back(w);
   endtask

   task automatic popCheck(input string tag);
      logic [15:0] e;
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checkOutput(tag, 64'(out_data), 64'(e));
   endtask

   task automatic waitValid(input string tag, input int expected_edges);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(n), 64'(expected_edges));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          edges;
      int          enabled;
      logic [3:0]  prev4;
      logic [3:0]  exp4;
      int          hits[16];
      int          recs;
      int          first_ret;
      int          once;

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      en4 = 1'b0; seed_load4 = 1'b0; seed4 = 4'h0; out_ready4 = 1'b0;
      exp_cnt = 0;
      repeat (2) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("reset_state", 64'(state), 64'(SEED0));
      checkOutput("reset_valid", 64'(out_valid), 64'(0));
      checkOutput("reset_data", 64'(out_data), 64'(0));
      checkOutput("reset_state4", 64'(state4), 64'(4'h1));
`ifdef RANDOM_LFSR_STAT_EN
      checkOutput("reset_word_cnt", 64'(word_cnt), 64'(0));
`endif

      $display("[TB] reset in the middle of FILL");
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      mstate = SEED0;
      repeat (5) mstate = 32'(lfsr_step(64'(mstate), 64'(POLY0)));
      checkOutput("fill_state_5", 64'(state), 64'(mstate));
      rst = 1'b1;
      #1;
      checkOutput("midfill_reset_state", 64'(state), 64'(SEED0));
      checkOutput("midfill_reset_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] first word after reset release");
      mstate = SEED0;
      pushModelWord();
      waitValid("first_word_edges", 16);
      checkOutput("first_word_state", 64'(state), 64'(mstate));

      $display("[TB] backpressure for 50 cycles");
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checkOutput("bp_valid", 64'(out_valid), 64'(1));
         checkOutput("bp_data", 64'(out_data), 64'(exp_q[0]));
         checkOutput("bp_state", 64'(state), 64'(mstate));
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      popCheck("bp_word");
      @(negedge clk);
      exp_cnt++;
      checkOutput("xfer_valid_low", 64'(out_valid), 64'(0));
`ifdef RANDOM_LFSR_STAT_EN
      checkOutput("xfer_word_cnt", 64'(word_cnt), 64'(exp_cnt));
`endif
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      pushModelWord();
      waitValid("rearm_edges", 16);
      checkOutput("rearm_state", 64'(state), 64'(mstate));

      $display("[TB] handshake with en low, then paused fill");
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      popCheck("word2");
      @(negedge clk);
      exp_cnt++;
      checkOutput("en0_xfer_valid_low", 64'(out_valid), 64'(0));
      out_ready = 1'b0;
      pushModelWord();
      edges   = 0;
      enabled = 0;
      while (out_valid !== 1'b1 && edges < 200) begin
         en = (edges % 2 == 0);
         @(negedge clk);
         if (en) enabled++;
         edges++;
      end
      en = 1'b0;
      checkOutput("pause_enabled_cycles", 64'(enabled), 64'(16));
      checkOutput("pause_edges", 64'(edges), 64'(31));
      checkOutput("pause_state", 64'(state), 64'(mstate));
      checkOutput("pause_data", 64'(out_data), 64'(exp_q[0]));

      $display("[TB] reseed colliding with handshake");
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
      void'(exp_q.pop_front());
      @(negedge clk);
      checkOutput("collide_valid", 64'(out_valid), 64'(0));
      checkOutput("zero_seed_state", 64'(state), 64'(SEED0));
`ifdef RANDOM_LFSR_STAT_EN
      checkOutput("collide_word_cnt", 64'(word_cnt), 64'(0));
      exp_cnt = 0;
`endif
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("after_collide_valid", 64'(out_valid), 64'(0));
      checkOutput("after_collide_state", 64'(state), 64'(SEED0));
      applyStimulus(1'b0, 1'b1, 32'h1, 1'b0);
      @(negedge clk);
      checkOutput("seed1_state", 64'(state), 64'(1));
      checkOutput("seed1_valid", 64'(out_valid), 64'(0));

      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      mstate = 32'h1;
      pushModelWord();
      waitValid("seed1_edges", 16);
      popCheck("seed1_word");
      checkOutput("seed1_word_state", 64'(state), 64'(mstate));

      $display("[TB] transfer (counter wrap when stats enabled)");
`ifdef RANDOM_LFSR_STAT_EN
      force dut.word_cnt = 32'hFFFFFFFF;
      #1;
      release dut.word_cnt;
`endif
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("final_xfer_valid", 64'(out_valid), 64'(0));
`ifdef RANDOM_LFSR_STAT_EN
      checkOutput("word_cnt_wrap", 64'(word_cnt), 64'(0));
`endif
      out_ready = 1'b0;

      $display("[TB] 4-bit LFSR full period");
      en4        = 1'b1;
      out_ready4 = 1'b1;
      prev4      = 4'h1;
      recs       = 0;
      first_ret  = -1;
      for (int k = 0; k < 16; k++) hits[k] = 0;
      for (int i = 0; i < 80 && recs < 15; i++) begin
         @(negedge clk);
         if (out_valid4 === 1'b1) begin
            exp4 = 4'(lfsr_step(64'(prev4), 64'(4'hC)));
            if (recs == 0) begin
               checkOutput("p4_first_state", 64'(state4), 64'(4'hC));
               checkOutput("p4_first_bit", 64'(out_data4), 64'(1));
            end
            checkOutput("p4_bit", 64'(out_data4), 64'(prev4[0]));
            checkOutput("p4_state", 64'(state4), 64'(exp4));
            if (state4 == 4'h1 && first_ret < 0) first_ret = recs + 1;
            hits[state4]++;
            prev4 = state4;
            recs++;
         end
      end
      en4 = 1'b0;
      once = 0;
      for (int k = 1; k < 16; k++) if (hits[k] == 1) once++;
      checkOutput("p4_records", 64'(recs), 64'(15));
      checkOutput("p4_period", 64'(first_ret), 64'(15));
      checkOutput("p4_distinct", 64'(once), 64'(15));
      checkOutput("p4_zero_unvisited", 64'(hits[0]), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
